// File: rtl/frame_shift_reg.sv
// ============================================================================
// Module   : frame_shift_reg
// Purpose  : Shift register with parallel load and WIDTH-bit left/right frame shifts.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_shift_reg #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             din,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] q,
  output logic             pop,
  output logic             busy,
  output logic             done
);

  localparam int c_CW = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_q, w_q_nxt;
  logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
  logic              r_dir, w_dir_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_q     <= RESET_VAL;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (mode == 2'b01) begin
            w_q_nxt = pdin;
          end else if (mode[1]) begin
            w_dir_nxt   = mode[0];
            w_cnt_nxt   = '0;
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        w_q_nxt   = r_dir ? {din, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], din};
        w_cnt_nxt = r_cnt + c_CW'(1);
        // Counter still shows the pre-increment count: this edge is shift number WIDTH.
        if (r_cnt == c_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign q    = r_q;
  assign pop  = r_dir ? r_q[0] : r_q[WIDTH-1];
  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: doc/frame_shift_reg.md
FRAME_SHIFT_REG -- requirements
Module: frame_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0, value loaded into q on reset.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  command strobe; sampled only in IDLE.
REQ-006 mode  input  2  command: 00 hold, 01 parallel load, 10 shift-left frame, 11 shift-right frame.
REQ-007 din  input  1  serial data input.
REQ-008 pdin  input  WIDTH  parallel load data.
REQ-009 q  output  WIDTH  registered parallel contents.
REQ-010 pop  output  1  bit leaving the register on the next shift (combinational from q and latched direction).
REQ-011 busy  output  1  high while a frame shift is in progress.
REQ-012 done  output  1  one-cycle pulse after the last shift of a frame.

Function
REQ-013 States SHALL be IDLE, SHIFT, DONE; encoding is free.
REQ-014 IDLE, start=0: q holds; no state change.
REQ-015 IDLE, start=1, mode=00: q holds; remain IDLE; no done pulse.
REQ-016 IDLE, start=1, mode=01: q <= pdin at that edge; remain IDLE; no done pulse.
REQ-017 IDLE, start=1, mode=1x: latch direction (dir=mode[0]), clear bit counter, go to SHIFT; q unchanged at that edge.
REQ-018 SHIFT, each cycle: left (dir=0) q <= {q[WIDTH-2:0], din}; right (dir=1) q <= {din, q[WIDTH-1:1]}; counter += 1.
REQ-019 SHIFT SHALL last exactly WIDTH cycles; on the edge performing shift number WIDTH, go to DONE.
REQ-020 DONE lasts one cycle, q holds, then returns to IDLE unconditionally.
REQ-021 busy = 1 exactly in SHIFT; done = 1 exactly in DONE.
REQ-022 pop = q[WIDTH-1] when dir=0, q[0] when dir=1; valid in all states, using last latched dir.
REQ-023 Latency: start accepted at edge N; first shift at edge N+1; last shift at edge N+WIDTH; done high during cycle after edge N+WIDTH; IDLE again after edge N+WIDTH+1.
REQ-024 start or mode changes during SHIFT or DONE SHALL be ignored; no queuing.
REQ-025 start in the DONE cycle SHALL be ignored; a new command is accepted in the following IDLE cycle at the earliest.
REQ-026 Bit counter width SHALL be ceil(log2(WIDTH+1)) bits; no wrap during a frame.
REQ-027 Unknown/illegal state SHALL recover to IDLE on the next edge.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, q=RESET_VAL, counter=0, dir=0, busy=0, done=0, pop = RESET_VAL[WIDTH-1].
REQ-029 Reset mid-SHIFT or mid-DONE SHALL abort the frame with no done pulse.
REQ-030 After rst_n deasserts, the first start is accepted at the first rising edge with rst_n=1.

Verification (WIDTH=4, RESET_VAL=0)
REQ-031 Reset: rst_n=0 asynchronously mid-cycle -> q=0000, busy=0, done=0, pop=0 without waiting for clk.
REQ-032 Load: IDLE, start=1, mode=01, pdin=1011 -> q=1011 next edge, busy=0, done=0, pop=1.
REQ-033 Left frame: q=1011, start mode=10, din=1,0,0,1 over 4 shift cycles -> pop sequence 1,0,1,1; q=1001; busy high 4 cycles; done one cycle.
REQ-034 Right frame: q=1011, start mode=11, din=0,1,1,0 -> pop sequence 1,1,0,1; q=0110; done one cycle after 4th shift.
REQ-035 Ignore: start mode=01 pdin=1111 during SHIFT and during DONE -> q unaffected, frame completes on schedule.
REQ-036 Abort: rst_n=0 after 2nd shift of a left frame -> q=0000, busy=0, no done; next start mode=10 runs a full 4-cycle frame.
